vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
Timing generator for the 640x480 @ 60 Hz VGA path. It divides the system clock into a pixel-rate enable and runs raw horizontal and vertical counters. From those counters it produces registered hsync, vsync and vidon, plus the hc/vc buses consumed by the downstream pattern/colour stages, such as the stripe generator. It sits directly between the board clock/reset and every pixel-colour block.

Parameters:
CLK_DIV, 2, system clocks per pixel (2 gives 25 MHz from 50 MHz); must be >= 1
H_TOTAL, 800, pixel clocks per line; hc counts 0..H_TOTAL-1; must be <= 1024
H_SYNC, 128, hsync is low while hc < H_SYNC
H_BP, 144, first active hc (sync + back porch)
H_FP, 784, first inactive hc after the active region (H_BP + 640)
V_TOTAL, 521, lines per frame; vc counts 0..V_TOTAL-1; must be <= 1024
V_SYNC, 2, vsync is low while vc < V_SYNC
V_BP, 31, first active vc
V_FP, 511, first inactive vc after the active region (V_BP + 480)

Ports:
clk  in  1  system clock; all state updates on the rising edge
clr  in  1  reset, synchronous, active-high
pix_ce  out  1  one-clk pulse marking a pixel-clock advance
hc  out  10  raw horizontal counter, including sync and porches
vc  out  10  raw vertical counter, including sync and porches
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
vidon  out  1  high while (H_BP <= hc < H_FP) and (V_BP <= vc < V_FP)
line_start  out  1  one-clk pulse on the edge where hc wraps to 0
frame_start  out  1  one-clk pulse on the edge where both hc and vc wrap to 0

Behaviour:
- Reset: when clr is high at a rising edge, the following are cleared on that edge:
  - div=0, hc=0, vc=0, pix_ce=0, line_start=0, frame_start=0, vidon=0
  - hsync=0 and vsync=0, because (0,0) lies inside both sync pulses
- clr takes priority over every other update and may assert at any point mid-frame.
- The first pix_ce after release occurs CLK_DIV edges after the first edge with clr low.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps to 0.
  - pix_ce is a registered pulse, high for the single clk following the edge where div reaches CLK_DIV-1.
  - With CLK_DIV=1, pix_ce is constantly high after the first post-reset edge.
- Counters advance only on edges where the advance condition holds:
  - hc increments; at H_TOTAL-1 it wraps to 0.
  - vc increments only when hc wraps; at V_TOTAL-1 (with hc wrapping) it wraps to 0.
  - hc, vc, hsync, vsync and vidon all change on the same edge.
- Registered decode: hsync, vsync and vidon are computed from the next counter values. Decode is therefore always consistent with the hc/vc currently on the outputs, with zero skew between them.
- Pulses:
  - line_start is high for exactly one clk, on the clk where hc becomes 0.
  - frame_start is high for exactly one clk, on the clk where hc and vc both become 0; line_start is also high on that clk.
  - Neither pulse asserts on the reset edge.
- Widths: hc and vc are 10 bits. Comparisons are unsigned.
- No other inputs exist; all outputs are valid every cycle.

Test Plan:
- Reset then run with defaults (CLK_DIV=2) -> pix_ce period is 2 clk; hsync rises when hc=128, 256 clk after release; line_start period is 1600 clk.
- Run one full frame -> frame_start period is 833600 clk; vsync is low for exactly 2 lines (3200 clk); hc never exceeds 799 and vc never exceeds 520.
- Check the active window -> vidon is first high at hc=144, vc=31 and last high at hc=783, vc=510; exactly 640x480 = 307200 pix_ce cycles with vidon=1 per frame.
- Wrap corner at hc=799, vc=520 -> the next pix_ce gives hc=0, vc=0, hsync=0, vsync=0, and line_start=1 with frame_start=1 on the same clk.
- Assert clr for 1 clk at hc=400, vc=200 -> the next edge shows hc=0, vc=0, pix_ce=0, vidon=0, hsync=0, vsync=0; the timing sequence then restarts identically to the post-power-up reset.
- Instance with CLK_DIV=1 -> pix_ce held at 1; line period is 800 clk; frame period is 416800 clk.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator: pixel-rate enable, raw h/v counters and
// registered sync/blanking decode that stays aligned with the counter outputs.
module vga_sync_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 128,
  parameter int H_BP    = 144,
  parameter int H_FP    = 784,
  parameter int V_TOTAL = 521,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 31,
  parameter int V_FP    = 511
) (
  input  logic       clk,
  input  logic       clr,
  output logic       pix_ce,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       line_start,
  output logic       frame_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
  localparam logic [9:0] H_BP_C = 10'(H_BP);
  localparam logic [9:0] H_FP_C = 10'(H_FP);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
  localparam logic [9:0] V_BP_C = 10'(V_BP);
  localparam logic [9:0] V_FP_C = 10'(V_FP);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic [9:0]       hc_nxt;
  logic [9:0]       vc_nxt;
  logic             h_wrap;
  logic             v_wrap;

  // Counters step on the edge after pix_ce is seen high, so decode can be
  // taken from the next values and land together with hc/vc.
  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
    h_wrap  = pix_ce && (hc == H_LAST);
    v_wrap  = h_wrap && (vc == V_LAST);
    hc_nxt  = hc;
    vc_nxt  = vc;
    if (pix_ce) begin
      hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
      if (h_wrap)
        vc_nxt = v_wrap ? 10'd0 : vc + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      vidon       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      pix_ce      <= (div == DIV_LAST);
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hsync       <= (hc_nxt >= H_SYNC_C);
      vsync       <= (vc_nxt >= V_SYNC_C);
      vidon       <= (hc_nxt >= H_BP_C) && (hc_nxt < H_FP_C) &&
                     (vc_nxt >= V_BP_C) && (vc_nxt < V_FP_C);
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized-reset bench for vga_sync_gen: four instances (default timing plus
// shrunken geometries at CLK_DIV 1/2/3) checked every clk against an arithmetic model.
module tb_vga_sync_gen;

  localparam int SHT = 20, SHS = 3, SHB = 5, SHF = 17;
  localparam int SVT = 12, SVS = 2, SVB = 3, SVF = 10;

  logic clk;
  logic clr;

  logic       ceA, hsA, vsA, vdA, lsA, fsA;
  logic [9:0] hcA, vcA;
  logic       ceB, hsB, vsB, vdB, lsB, fsB;
  logic [9:0] hcB, vcB;
  logic       ceC, hsC, vsC, vdC, lsC, fsC;
  logic [9:0] hcC, vcC;
  logic       ceD, hsD, vsD, vdD, lsD, fsD;
  logic [9:0] hcD, vcD;

  int checks = 0;
  int fails = 0;
  int t = 0;
  int lsCountA = 0;
  int fsCountC = 0;

  vga_sync_gen dutA (
    .clk(clk), .clr(clr), .pix_ce(ceA), .hc(hcA), .vc(vcA), .hsync(hsA),
    .vsync(vsA), .vidon(vdA), .line_start(lsA), .frame_start(fsA)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_TOTAL(SHT), .H_SYNC(SHS), .H_BP(SHB), .H_FP(SHF),
    .V_TOTAL(SVT), .V_SYNC(SVS), .V_BP(SVB), .V_FP(SVF)
  ) dutB (
    .clk(clk), .clr(clr), .pix_ce(ceB), .hc(hcB), .vc(vcB), .hsync(hsB),
    .vsync(vsB), .vidon(vdB), .line_start(lsB), .frame_start(fsB)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_TOTAL(SHT), .H_SYNC(SHS), .H_BP(SHB), .H_FP(SHF),
    .V_TOTAL(SVT), .V_SYNC(SVS), .V_BP(SVB), .V_FP(SVF)
  ) dutC (
    .clk(clk), .clr(clr), .pix_ce(ceC), .hc(hcC), .vc(vcC), .hsync(hsC),
    .vsync(vsC), .vidon(vdC), .line_start(lsC), .frame_start(fsC)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_TOTAL(SHT), .H_SYNC(SHS), .H_BP(SHB), .H_FP(SHF),
    .V_TOTAL(SVT), .V_SYNC(SVS), .V_BP(SVB), .V_FP(SVF)
  ) dutD (
    .clk(clk), .clr(clr), .pix_ce(ceD), .hc(hcD), .vc(vcD), .hsync(hsD),
    .vsync(vsD), .vidon(vdD), .line_start(lsD), .frame_start(fsD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs t edges after the last reset edge: the pixel count is the
  // number of completed divider periods, and every output follows from it.
  function automatic logic [25:0] expectOut(input int d, input int ht, input int hs,
                                            input int hb, input int hf, input int vt,
                                            input int vs, input int vb, input int vf,
                                            input int tt);
    int p, pp, h, v;
    logic ce, ls, fs, hsy, vsy, vid;
    p   = (tt >= 1) ? (tt - 1) / d : 0;
    pp  = (tt >= 2) ? (tt - 2) / d : 0;
    ce  = (tt >= d) && ((tt % d) == 0);
    h   = p % ht;
    v   = (p / ht) % vt;
    ls  = (p != pp) && (h == 0);
    fs  = ls && (v == 0);
    hsy = (h >= hs);
    vsy = (v >= vs);
    vid = (h >= hb) && (h < hf) && (v >= vb) && (v < vf);
    return {ce, 10'(h), 10'(v), hsy, vsy, vid, ls, fs};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s t=%0d: got %h expected %h", tag, t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (clr) t = 0;
    else t++;
    #1;
    if (lsA) lsCountA++;
    if (fsC) fsCountC++;
    checkOutput("default", 32'({ceA, hcA, vcA, hsA, vsA, vdA, lsA, fsA}),
                32'(expectOut(2, 800, 128, 144, 784, 521, 2, 31, 511, t)));
    checkOutput("div2", 32'({ceB, hcB, vcB, hsB, vsB, vdB, lsB, fsB}),
                32'(expectOut(2, SHT, SHS, SHB, SHF, SVT, SVS, SVB, SVF, t)));
    checkOutput("div1", 32'({ceC, hcC, vcC, hsC, vsC, vdC, lsC, fsC}),
                32'(expectOut(1, SHT, SHS, SHB, SHF, SVT, SVS, SVB, SVF, t)));
    checkOutput("div3", 32'({ceD, hcD, vcD, hsD, vsD, vdD, lsD, fsD}),
                32'(expectOut(3, SHT, SHS, SHB, SHF, SVT, SVS, SVB, SVF, t)));
  endtask

  task automatic applyStimulus(input int clrCycles, input int runCycles);
    clr = 1'b1;
    for (int i = 0; i < clrCycles; i++) tick();
    clr = 1'b0;
    for (int i = 0; i < runCycles; i++) tick();
  endtask

  initial begin
    clr = 1'b1;
    tick();
    checkOutput("reset_state", 32'({ceA, hcA, vcA, hsA, vsA, vdA, lsA, fsA}), 32'h0);

    lsCountA = 0;
    fsCountC = 0;
    applyStimulus(2, 4000);
    checkOutput("line_count_default", 32'(lsCountA), 32'((4000 - 1) / 2 / 800));
    checkOutput("frame_count_div1", 32'(fsCountC), 32'((4000 - 1) / (SHT * SVT)));

    for (int s = 0; s < 8; s++)
      applyStimulus(int'($urandom_range(1, 3)), int'($urandom_range(50, 1500)));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
